input_loop_feeder: RTL
======================

INPUT_LOOP_FEEDER -- requirements
Module: input_loop_feeder

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The clock and reset ports SHALL be named clk_i and rst_n_i, following the codebase port naming.
REQ-003 Parameter Tn_p, default 2: lanes per chunk, equal to the MAC unroll factor; legal range >=1.
REQ-004 Parameter N_p, default 8: total input channels; legal range >=1.
REQ-005 Derived constants: C = ceil(N_p/Tn_p) chunks; AW = max(1, clog2(C)).
REQ-006 Ports (name  direction  width  meaning):
- clk_i  in  1  clock.
- rst_n_i  in  1  async active-low reset.
- start_i  in  1  begin one output-pixel accumulation.
- init_i  in  32  initial output value (IEEE single bits), sampled with start_i.
- busy_o  out  1  high whenever state != IDLE.
- rd_en_o  out  1  read strobe to the fm and weight buffers.
- rd_addr_o  out  AW  chunk index for both buffers.
- fm_rd_data_i  in  Tn_p x 32  fm buffer read data; valid 1 cycle after rd_en_o.
- wt_rd_data_i  in  Tn_p x 32  weight buffer read data; same timing as fm_rd_data_i.
- mac_fm_o  out  Tn_p x 32  fm lanes to the combinational MAC.
- mac_wt_o  out  Tn_p x 32  weight lanes to the MAC.
- mac_init_o  out  32  running partial sum to the MAC.
- mac_sum_i  in  32  MAC result; combinational from the mac_* outputs in the same cycle.
- res_valid_o  out  1  result valid.
- res_data_o  out  32  final accumulated value.
- res_ready_i  in  1  result consumer ready.

Function
REQ-007 The module SHALL perform no arithmetic; it SHALL only sequence, mask and register 32-bit words.
REQ-008 FSM states SHALL be IDLE, RUN and OUT.
REQ-009 IDLE: on start_i=1, the module SHALL load acc<=init_i, clear rd_cnt and acc_cnt, and go to RUN.
REQ-010 RUN: while rd_cnt<C, the module SHALL assert rd_en_o=1 with rd_addr_o=rd_cnt and increment rd_cnt.
REQ-011 RUN: rd_en_o SHALL be 0 once rd_cnt=C.
REQ-012 Register dv SHALL equal the previous cycle's rd_en_o.
REQ-013 When dv=1, the module SHALL capture acc<=mac_sum_i and increment acc_cnt.
REQ-014 When dv=1 and acc_cnt=C-1, the module SHALL go to OUT on the next edge.
REQ-015 mac_init_o SHALL equal acc at all times.
REQ-016 mac_fm_o[j] and mac_wt_o[j] SHALL equal fm_rd_data_i[j] and wt_rd_data_i[j], except as masked by REQ-017.
REQ-017 Tail masking: for the chunk read at index k, lane j SHALL be driven 32'h0 on both mac_fm_o[j] and mac_wt_o[j] when k*Tn_p+j >= N_p.
REQ-018 The masking rule SHALL use the registered chunk index of the data in flight, not rd_cnt.
REQ-019 OUT: res_valid_o=1 and res_data_o=acc; both SHALL be held stable until res_ready_i=1.
REQ-020 OUT: on the res_valid_o&res_ready_i handshake, the module SHALL return to IDLE.
REQ-021 start_i SHALL be ignored outside IDLE, including in the handshake cycle.
REQ-022 Latency: with start_i accepted at cycle t, rd_addr_o=k SHALL be issued at cycle t+1+k and res_valid_o SHALL rise at cycle t+C+2.
REQ-023 Throughput: one chunk per cycle; there SHALL be no bubbles between reads.
REQ-024 mac_sum_i SHALL be sampled only when dv=1 and ignored otherwise.
REQ-025 res_data_o SHALL be 0 when res_valid_o=0.

Reset
REQ-026 rst_n_i=0 SHALL immediately force state IDLE, acc=0, rd_cnt=0, acc_cnt=0 and dv=0.
REQ-027 While in reset, busy_o, rd_en_o, rd_addr_o, res_valid_o and res_data_o SHALL all be 0.
REQ-028 Reset asserted mid-RUN or mid-OUT SHALL abort the operation; an in-flight buffer read SHALL be discarded and no result emitted.
REQ-029 The first start_i SHALL be accepted on the first rising edge after rst_n_i deasserts.

Verification
REQ-030 The bench SHALL pair the module with a behavioural MAC computing mac_init_o + sum of (mac_fm_o*mac_wt_o) and 1-cycle-latency buffer models.
REQ-031 Basic accumulation (Tn_p=2, N_p=3): fm={20,5,3}, wt={5,10,2}, init=1.0 -> res_data_o=157.0 (32'h431D0000).
REQ-032 Same run, cycle-level: rd_addr 0 at t+1, rd_addr 1 at t+2, res_valid_o at t+4.
REQ-033 Tail masking: the chunk-1 lane-1 buffer holds 7.0 -> mac_fm_o[1]=mac_wt_o[1]=0 while dv=1 for chunk 1; the result is unaffected.
REQ-034 Backpressure: res_ready_i=0 for 5 cycles -> res_valid_o and res_data_o are stable and a start_i pulse is ignored; after the handshake the state is IDLE.
REQ-035 Reset mid-RUN: rst_n_i low at t+2 -> all outputs 0 within the same cycle; a fresh start produces the correct result with no residue from the aborted run.
REQ-036 Degenerate case (Tn_p=N_p=1): fm=2.0, wt=3.0, init=0.5 -> C=1, res_data_o=6.5 (32'h40D00000) at t+3.

Source files
------------

// File: rtl/input_loop_feeder.sv
// Purpose: sequences chunked fm/weight buffer reads into a combinational MAC and accumulates one output pixel.
// Latency: start accepted at cycle t -> chunk k read at t+1+k, result valid at t+C+2.
// Backpressure: result held stable in OUT until res_ready_i; new starts only accepted in IDLE.
module input_loop_feeder #(
    parameter int Tn_p = 2,
    parameter int N_p  = 8,
    localparam int C   = (N_p + Tn_p - 1) / Tn_p,
    localparam int AW  = (C > 1) ? $clog2(C) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic [31:0]          init_i,
    output logic                 busy_o,
    output logic                 rd_en_o,
    output logic [AW-1:0]        rd_addr_o,
    input  logic [Tn_p*32-1:0]   fm_rd_data_i,
    input  logic [Tn_p*32-1:0]   wt_rd_data_i,
    output logic [Tn_p*32-1:0]   mac_fm_o,
    output logic [Tn_p*32-1:0]   mac_wt_o,
    output logic [31:0]          mac_init_o,
    input  logic [31:0]          mac_sum_i,
    output logic                 res_valid_o,
    output logic [31:0]          res_data_o,
    input  logic                 res_ready_i
);

    // Counters must be able to hold C itself, one more value than the address range.
    localparam int CW = $clog2(C + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OUT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   rd_cnt;
    logic [CW-1:0]   acc_cnt;
    logic [AW-1:0]   dv_idx;
    logic            dv;
    logic [31:0]     acc;
    logic            rd_en;

    // Reads issue back to back while chunks remain; nothing is read outside RUN.
    assign rd_en = (state == RUN) && (rd_cnt < CW'(C));

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave RUN once the last chunk's MAC result is captured.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (dv && (acc_cnt == CW'(C - 1))) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                if (res_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read/accumulate bookkeeping; dv and dv_idx track the chunk whose data arrives next cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_cnt  <= '0;
            acc_cnt <= '0;
            dv_idx  <= '0;
            dv      <= 1'b0;
            acc     <= '0;
        end else begin
            dv <= rd_en;
            if (rd_en) begin
                rd_cnt <= rd_cnt + CW'(1);
                dv_idx <= rd_cnt[AW-1:0];
            end
            if ((state == IDLE) && start_i) begin
                acc     <= init_i;
                rd_cnt  <= '0;
                acc_cnt <= '0;
            end else if (dv) begin
                acc     <= mac_sum_i;
                acc_cnt <= acc_cnt + CW'(1);
            end
        end
    end

    // Zero lanes past the last real channel so the padded tail contributes nothing.
    always_comb begin
        mac_fm_o = fm_rd_data_i;
        mac_wt_o = wt_rd_data_i;
        for (int j = 0; j < Tn_p; j++) begin
            if ((int'(dv_idx) * Tn_p + j) >= N_p) begin
                mac_fm_o[j*32 +: 32] = 32'h0;
                mac_wt_o[j*32 +: 32] = 32'h0;
            end
        end
    end

    assign busy_o      = (state != IDLE);
    assign rd_en_o     = rd_en;
    assign rd_addr_o   = rd_en ? rd_cnt[AW-1:0] : '0;
    assign mac_init_o  = acc;
    assign res_valid_o = (state == OUT);
    assign res_data_o  = (state == OUT) ? acc : 32'h0;

endmodule
